// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
//
// Parallel-in / serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake into a one-word hold buffer. From there it is moved
// into the shift register and sent out one bit per enabled cycle. Frame
// markers flag the first and last bit of every frame.
//
// The hold buffer can accept the next word while the current frame is still
// shifting. When the last bit of a frame is consumed and a word is waiting,
// the next frame starts on the following cycle. Back-to-back frames therefore
// have no idle bit between them.
//
// Parameters
//   WIDTH      bits per frame (>= 2)
//   MSB_FIRST  1: word bit WIDTH-1 is sent first; 0: word bit 0 is sent first
//
// Ports
//   i_clk          clock; all state updates on the rising edge
//   i_reset        synchronous, active-high reset
//   i_load_valid   i_data_in holds a word to transmit
//   o_load_ready   hold buffer is empty (word accepted when valid is also 1)
//   i_data_in      word to serialise; sampled only in the accept cycle
//   i_shift_en     advance one bit this cycle; ignored while idle
//   o_ser_out      current serial bit
//   o_ser_valid    o_ser_out carries a frame bit
//   o_frame_start  o_ser_out is the first bit of a frame
//   o_frame_last   o_ser_out is the final bit of a frame
//   o_busy         a frame is shifting or a word is waiting in the hold buffer
// -----------------------------------------------------------------------------
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_shift_en,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_frame_start,
    output logic             o_frame_last,
    output logic             o_busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Registered state
    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hold_data;
    logic             r_hold_full;

    // Next-state values
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_hold_data_nxt;
    logic             w_hold_full_nxt;

    logic             w_accept;
    logic             w_last_bit;

    // Move the shift register one place toward the output end, with zero
    // filled in at the far end.
    function automatic logic [WIDTH-1:0] shift_toward_out(
        input logic [WIDTH-1:0] s
    );
        logic [WIDTH-1:0] r;
        if (MSB_FIRST != 0) begin
            r = {s[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, s[WIDTH-1:1]};
        end
        return r;
    endfunction

    // A word is only accepted into an empty hold buffer. Because of this, an
    // accept never coincides with a hold-to-shift transfer: a transfer needs a
    // full buffer.
    assign w_accept   = i_load_valid && !r_hold_full;
    assign w_last_bit = (r_cnt == LAST_CNT);

    // ---- state register ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold_data <= w_hold_data_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_cnt_nxt       = r_cnt;
        w_hold_data_nxt = r_hold_data;
        w_hold_full_nxt = r_hold_full;

        if (w_accept) begin
            w_hold_data_nxt = i_data_in;
            w_hold_full_nxt = 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_sreg_nxt      = r_hold_data;
                    w_hold_full_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = SHIFT;
                end
            end

            SHIFT: begin
                if (i_shift_en) begin
                    if (!w_last_bit) begin
                        w_sreg_nxt = shift_toward_out(r_sreg);
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end else if (r_hold_full) begin
                        // Chain straight into the waiting word: no idle bit.
                        w_sreg_nxt      = r_hold_data;
                        w_hold_full_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                    end else begin
                        // The last bit is shifted out as well. This leaves the
                        // register empty, so the serial line rests at 0 while idle.
                        w_sreg_nxt  = shift_toward_out(r_sreg);
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---- output decode (registers only) ----
    assign o_load_ready  = !r_hold_full;
    assign o_ser_out     = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];
    assign o_ser_valid   = (r_state == SHIFT);
    assign o_frame_start = o_ser_valid && (r_cnt == '0);
    assign o_frame_last  = o_ser_valid && w_last_bit;
    assign o_busy        = o_ser_valid || r_hold_full;

endmodule
